// File: rtl/rf_pkg.sv
// Shared types, default sizes and width helpers for the banked register file.
package rf_pkg;

  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_NBANKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CLEAR       = 2'd1,
    ST_SWITCH_WAIT = 2'd2
  } rf_state_e;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Bank-select width; a single-bank file still needs one bit.
  function automatic int unsigned min1_bits(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bank-clear / deferred-switch controller: owns ActiveBank, clear sequencing and request errors.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NBANKS = RF_NBANKS
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           SwitchReq,
  input  logic [min1_bits(NBANKS)-1:0]   SwitchBank,
  input  logic                           ClearReq,
  input  logic [min1_bits(NBANKS)-1:0]   ClearBank,
  output logic [min1_bits(NBANKS)-1:0]   o_active_bank,
  output logic                           o_busy,
  output logic                           o_req_err,
  output logic                           o_clr_we_c,
  output logic [min1_bits(NBANKS)-1:0]   o_clr_bank,
  output logic [clog2(DEPTH)-1:0]        o_clr_idx
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned BW = min1_bits(NBANKS);

  rf_state_e       r_state;
  logic [BW-1:0]   r_active;
  logic [BW-1:0]   r_clr_bank;
  logic [BW-1:0]   r_pend_bank;
  logic [AW-1:0]   r_cnt;
  logic            r_pend;
  logic            r_busy;
  logic            r_err;

  logic [BW-1:0]   w_idle_target;
  logic            w_latch;
  logic            w_last;

  // In IDLE a simultaneous switch is applied first, so a clear is judged against the new bank.
  assign w_idle_target = SwitchReq ? SwitchBank : r_active;
  // A switch into the bank being scrubbed must wait for the scrub to finish.
  assign w_latch       = SwitchReq && !r_pend && (SwitchBank == r_clr_bank);
  assign w_last        = (r_cnt == AW'(DEPTH - 1));

  // Controller state machine; every state change happens on the falling clock edge.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_active    <= '0;
      r_clr_bank  <= '0;
      r_pend_bank <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (SwitchReq) r_active <= SwitchBank;
          if (ClearReq) begin
            if (ClearBank != w_idle_target) begin
              r_state    <= ST_CLEAR;
              r_clr_bank <= ClearBank;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (ClearReq || (SwitchReq && r_pend)) r_err <= 1'b1;
          if (w_latch) begin
            r_pend      <= 1'b1;
            r_pend_bank <= SwitchBank;
          end else if (SwitchReq && !r_pend) begin
            r_active <= SwitchBank;
          end
          r_cnt <= r_cnt + AW'(1);
          if (w_last) begin
            if (r_pend || w_latch) begin
              r_state <= ST_SWITCH_WAIT;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_SWITCH_WAIT: begin
          if (ClearReq || SwitchReq) r_err <= 1'b1;
          r_active <= r_pend_bank;
          r_pend   <= 1'b0;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_active_bank = r_active;
  assign o_busy        = r_busy;
  assign o_req_err     = r_err;
  assign o_clr_we_c    = (r_state == ST_CLEAR);
  assign o_clr_bank    = r_clr_bank;
  assign o_clr_idx     = r_cnt;

endmodule

// File: rtl/banked_register_file.sv
// Multi-context MIPS register file: NBANKS banks, two async read ports, one write port, HW bank clear.
module banked_register_file
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NBANKS   = RF_NBANKS,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [clog2(DEPTH)-1:0]      ReadReg1,
  input  logic [clog2(DEPTH)-1:0]      ReadReg2,
  output logic [WIDTH-1:0]             ReadData1,
  output logic [WIDTH-1:0]             ReadData2,
  input  logic [clog2(DEPTH)-1:0]      WriteReg,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic                         RegWrite,
  input  logic                         ProcessCheck,
  input  logic [WIDTH-1:0]             CurrentProcessState,
  input  logic                         SwitchReq,
  input  logic [min1_bits(NBANKS)-1:0] SwitchBank,
  input  logic                         ClearReq,
  input  logic [min1_bits(NBANKS)-1:0] ClearBank,
  output logic [min1_bits(NBANKS)-1:0] ActiveBank,
  output logic                         Busy,
  output logic                         ReqErr
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned BW = min1_bits(NBANKS);

  logic [WIDTH-1:0] r_mem [NBANKS][DEPTH];

  logic [BW-1:0]    w_active;
  logic             w_clr_we;
  logic [BW-1:0]    w_clr_bank;
  logic [AW-1:0]    w_clr_idx;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_data;

  rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .NBANKS (NBANKS)
  ) u_ctrl (
    .CLK           (CLK),
    .RST           (RST),
    .SwitchReq     (SwitchReq),
    .SwitchBank    (SwitchBank),
    .ClearReq      (ClearReq),
    .ClearBank     (ClearBank),
    .o_active_bank (w_active),
    .o_busy        (Busy),
    .o_req_err     (ReqErr),
    .o_clr_we_c    (w_clr_we),
    .o_clr_bank    (w_clr_bank),
    .o_clr_idx     (w_clr_idx)
  );

  // Process-state write wins over normal write data; register 0 may be hardwired.
  assign w_wr_en   = (ProcessCheck || RegWrite) && !(ZERO_REG && (WriteReg == '0));
  assign w_wr_data = ProcessCheck ? CurrentProcessState : WriteData;

  // Storage: datapath write to the active bank, scrub write to the clear bank (scrub wins on overlap).
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < int'(NBANKS); b++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_mem[b][i] <= '0;
        end
      end
    end else begin
      if (w_wr_en) r_mem[w_active][WriteReg] <= w_wr_data;
      if (w_clr_we) r_mem[w_clr_bank][w_clr_idx] <= '0;
    end
  end

  assign ReadData1  = (ZERO_REG && (ReadReg1 == '0)) ? '0 : r_mem[w_active][ReadReg1];
  assign ReadData2  = (ZERO_REG && (ReadReg2 == '0)) ? '0 : r_mem[w_active][ReadReg2];
  assign ActiveBank = w_active;

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: driver + reference model push expectations, monitor checks.
module tb_banked_register_file;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [1:0]  ab;
    logic        busy;
    logic        err;
    string       tag;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] ReadData1, ReadData2, WriteData, CurrentProcessState;
  logic        RegWrite, ProcessCheck, SwitchReq, ClearReq;
  logic [1:0]  SwitchBank, ClearBank, ActiveBank;
  logic        Busy, ReqErr;

  banked_register_file dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .ReadReg1            (ReadReg1),
    .ReadReg2            (ReadReg2),
    .ReadData1           (ReadData1),
    .ReadData2           (ReadData2),
    .WriteReg            (WriteReg),
    .WriteData           (WriteData),
    .RegWrite            (RegWrite),
    .ProcessCheck        (ProcessCheck),
    .CurrentProcessState (CurrentProcessState),
    .SwitchReq           (SwitchReq),
    .SwitchBank          (SwitchBank),
    .ClearReq            (ClearReq),
    .ClearBank           (ClearBank),
    .ActiveBank          (ActiveBank),
    .Busy                (Busy),
    .ReqErr              (ReqErr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Staged stimulus for the next cycle
  logic        s_rst, s_rw, s_pc, s_sreq, s_creq;
  logic [4:0]  s_rr1, s_rr2, s_wr;
  logic [31:0] s_wd, s_cps;
  logic [1:0]  s_sb, s_cb;
  string       s_tag;

  // Reference model: plain arrays plus a "scrub in progress" description
  logic [31:0] m_mem [4][32];
  int          m_active;
  bit          m_clearing;
  int          m_clr_bank;
  int          m_clr_next;
  bit          m_pend;
  int          m_pend_bank;
  bit          m_wait;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_fail;

  function automatic void model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 32; i++) m_mem[b][i] = 32'h0;
    m_active   = 0;
    m_clearing = 0;
    m_clr_bank = 0;
    m_clr_next = 0;
    m_pend     = 0;
    m_pend_bank = 0;
    m_wait     = 0;
  endfunction

  // Advance the model by one falling edge and queue what the DUT should show afterwards.
  function automatic void model_step();
    exp_t e;
    bit   err;
    err = 0;
    if (s_rst) begin
      model_reset();
    end else begin
      if ((s_pc || s_rw) && s_wr != 5'd0) m_mem[m_active][s_wr] = s_pc ? s_cps : s_wd;
      if (m_wait) begin
        if (s_sreq || s_creq) err = 1;
        m_active = m_pend_bank;
        m_pend   = 0;
        m_wait   = 0;
      end else if (m_clearing) begin
        m_mem[m_clr_bank][m_clr_next] = 32'h0;
        if (s_creq) err = 1;
        if (s_sreq) begin
          if (m_pend) err = 1;
          else if (int'(s_sb) == m_clr_bank) begin
            m_pend = 1;
            m_pend_bank = int'(s_sb);
          end else m_active = int'(s_sb);
        end
        m_clr_next = m_clr_next + 1;
        if (m_clr_next == 32) begin
          m_clearing = 0;
          if (m_pend) m_wait = 1;
        end
      end else begin
        if (s_sreq) m_active = int'(s_sb);
        if (s_creq) begin
          if (int'(s_cb) != m_active) begin
            m_clearing = 1;
            m_clr_bank = int'(s_cb);
            m_clr_next = 0;
          end else err = 1;
        end
      end
    end
    e.rd1  = (s_rr1 == 5'd0) ? 32'h0 : m_mem[m_active][s_rr1];
    e.rd2  = (s_rr2 == 5'd0) ? 32'h0 : m_mem[m_active][s_rr2];
    e.ab   = 2'(m_active);
    e.busy = m_clearing || m_wait;
    e.err  = err;
    e.tag  = s_tag;
    sb_q.push_back(e);
  endfunction

  // Drive the staged inputs just after the rising edge; state updates at the following falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
    RST                 = s_rst;
    ReadReg1            = s_rr1;
    ReadReg2            = s_rr2;
    WriteReg            = s_wr;
    WriteData           = s_wd;
    RegWrite            = s_rw;
    ProcessCheck        = s_pc;
    CurrentProcessState = s_cps;
    SwitchReq           = s_sreq;
    SwitchBank          = s_sb;
    ClearReq            = s_creq;
    ClearBank           = s_cb;
    model_step();
    s_rw   = 0;
    s_pc   = 0;
    s_sreq = 0;
    s_creq = 0;
  endtask

  task automatic switch_to(input logic [1:0] b);
    s_sreq = 1;
    s_sb   = b;
    step();
  endtask

  task automatic read_all(input string tag);
    s_tag = tag;
    for (int i = 0; i < 16; i++) begin
      s_rr1 = 5'(2 * i);
      s_rr2 = 5'(2 * i + 1);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endfunction

  // Monitor: sample away from the falling (active) edge and compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".rd1"}, ReadData1, e.rd1);
        check({e.tag, ".rd2"}, ReadData2, e.rd2);
        check({e.tag, ".active"}, 32'(ActiveBank), 32'(e.ab));
        check({e.tag, ".busy"}, 32'(Busy), 32'(e.busy));
        check({e.tag, ".reqerr"}, 32'(ReqErr), 32'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1; ReadReg1 = 0; ReadReg2 = 0; WriteReg = 0; WriteData = 0; RegWrite = 0;
    ProcessCheck = 0; CurrentProcessState = 0; SwitchReq = 0; SwitchBank = 0;
    ClearReq = 0; ClearBank = 0;
    s_rst = 1; s_rw = 0; s_pc = 0; s_sreq = 0; s_creq = 0;
    s_rr1 = 0; s_rr2 = 0; s_wr = 0; s_wd = 0; s_cps = 0; s_sb = 0; s_cb = 0;
    s_tag = "reset";
    model_reset();

    // 1: reset, every register of every bank reads zero
    idle(2);
    s_rst = 0;
    for (int b = 0; b < 4; b++) begin
      switch_to(2'(b));
      read_all("t1_read");
    end
    switch_to(2'd0);

    // 2: ProcessCheck priority and hardwired r0
    s_tag = "t2_pcheck";
    s_rw = 1; s_pc = 1; s_wd = 32'hDEADBEEF; s_cps = 32'h12; s_wr = 5'd5; s_rr1 = 5'd5; s_rr2 = 5'd0;
    step();
    s_tag = "t2_r0";
    s_rw = 1; s_wd = 32'hFFFF_FFFF; s_wr = 5'd0; s_rr1 = 5'd0; s_rr2 = 5'd5;
    step();

    // 3: fill bank1, scrub it from bank0, then view it
    s_tag = "t3_fill";
    switch_to(2'd1);
    for (int i = 1; i < 32; i++) begin
      s_rw = 1; s_wr = 5'(i); s_wd = 32'(i); s_rr1 = 5'(i); s_rr2 = 5'(i - 1);
      step();
    end
    switch_to(2'd0);
    s_tag = "t3_clear";
    s_creq = 1; s_cb = 2'd1;
    step();
    idle(33);
    switch_to(2'd1);
    read_all("t3_after");

    // 4: clear of the active bank is rejected
    s_tag = "t4";
    switch_to(2'd2);
    s_rw = 1; s_wr = 5'd3; s_wd = 32'hA5A5_0003; s_rr1 = 5'd3;
    step();
    s_creq = 1; s_cb = 2'd2;
    step();
    idle(3);

    // 5: immediate switch and deferred switch during a scrub of bank3
    s_tag = "t5";
    switch_to(2'd3);
    for (int i = 1; i < 6; i++) begin
      s_rw = 1; s_wr = 5'(i * 5); s_wd = $urandom; step();
    end
    switch_to(2'd0);
    s_creq = 1; s_cb = 2'd3; s_rr1 = 5'd5; s_rr2 = 5'd10;
    step();
    for (int c = 0; c < 36; c++) begin
      if (c == 2) begin s_sreq = 1; s_sb = 2'd1; end
      if (c == 5) begin s_sreq = 1; s_sb = 2'd3; end
      if (c == 8) begin s_sreq = 1; s_sb = 2'd2; end
      if (c == 12) begin s_creq = 1; s_cb = 2'd0; end
      step();
    end
    read_all("t5_bank3");

    // 6: reset in the middle of a scrub, then a fresh scrub is accepted
    s_tag = "t6";
    switch_to(2'd0);
    s_rw = 1; s_wr = 5'd7; s_wd = 32'h7777_0007; step();
    s_creq = 1; s_cb = 2'd2; step();
    idle(10);
    s_rst = 1; step();
    s_rst = 0;
    s_rr1 = 5'd7; step();
    s_creq = 1; s_cb = 2'd1; step();
    idle(34);

    // Randomised traffic
    s_tag = "rand";
    for (int c = 0; c < 1500; c++) begin
      s_rst  = ($urandom_range(0, 299) == 0);
      s_rw   = $urandom_range(0, 1) != 0;
      s_pc   = ($urandom_range(0, 7) == 0);
      s_wr   = 5'($urandom);
      s_wd   = $urandom;
      s_cps  = $urandom;
      s_rr1  = 5'($urandom);
      s_rr2  = 5'($urandom);
      s_sreq = ($urandom_range(0, 11) == 0);
      s_sb   = 2'($urandom);
      s_creq = ($urandom_range(0, 19) == 0);
      s_cb   = 2'($urandom);
      step();
    end
    s_rst = 0;
    idle(2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
